// File: rtl/serial_word_rx.sv
// Reassembles start/data/stop framed serial words into parallel form; valid or frame_err registered one cycle after the stop-bit sample.
// No backpressure: en=0 stalls the FSM, counter and shift register; output strobes still clear after one cycle.
module serial_word_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             en,
  output logic [WIDTH-1:0] par_out,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;

  // The first data bit must end up at the MSB (MSB_FIRST) or at bit 0.
  always_comb begin
    shifted = shreg;
    if (MSB_FIRST) shifted = {shreg[WIDTH-2:0], s_in};
    else           shifted = {s_in, shreg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      par_out   <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (!s_in) begin
              state <= DATA;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          DATA: begin
            if (cnt > LAST) begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end else begin
              shreg <= shifted;
              if (cnt == LAST) begin
                state <= STOP;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          STOP: begin
            // A bad stop bit is dropped, never reinterpreted as a start bit.
            if (s_in) begin
              par_out <= shreg;
              valid   <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
// Bench for serial_word_rx: drives both bit orders from one serial line and scoreboards decoded words.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_in = 1'b1;
  logic       en = 1'b0;
  logic [3:0] par_a, par_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       err;
    logic [3:0] word;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [3:0] last_a = 4'h0;
  logic [3:0] last_b = 4'h0;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset(reset), .s_in(s_in), .en(en),
    .par_out(par_a), .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
  );

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset(reset), .s_in(s_in), .en(en),
    .par_out(par_b), .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, let the edge happen, then check busy.
  task automatic step(input logic s, input logic e, input logic exp_busy);
    s_in = s;
    en   = e;
    @(posedge clk);
    #1;
    chk("busy_a", int'(busy_a), int'(exp_busy));
    chk("busy_b", int'(busy_b), int'(exp_busy));
  endtask

  // d[3] is sent first; exp_b is the hand-computed LSB-first decode.
  task automatic frame(input logic [3:0] d, input logic [3:0] exp_b,
                       input logic stop, input bit tog);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      if (tog) step(~d[i], 1'b0, 1'b1);
      step(d[i], 1'b1, 1'b1);
    end
    if (stop) begin
      qa.push_back('{err: 1'b0, word: d});
      qb.push_back('{err: 1'b0, word: exp_b});
      last_a = d;
      last_b = exp_b;
    end else begin
      qa.push_back('{err: 1'b1, word: last_a});
      qb.push_back('{err: 1'b1, word: last_b});
    end
    if (tog) step(~stop, 1'b0, 1'b1);
    step(stop, 1'b1, 1'b0);
  endtask

  initial begin
    fork
      begin : stimulus
        @(posedge clk);
        #1;
        chk("rst_par_a", int'(par_a), 0);
        chk("rst_par_b", int'(par_b), 0);
        chk("rst_valid_a", int'(valid_a), 0);
        chk("rst_ferr_a", int'(ferr_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        frame(4'b0101, 4'b1010, 1'b1, 1'b0);
        frame(4'b1100, 4'b0011, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        frame(4'b1111, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        frame(4'b0101, 4'b1010, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Abandon a frame partway through its data bits.
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        s_in  = 1'b1;
        en    = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_par_a", int'(par_a), 0);
        chk("midrst_par_b", int'(par_b), 0);
        chk("midrst_valid_a", int'(valid_a), 0);
        chk("midrst_ferr_a", int'(ferr_a), 0);
        chk("midrst_busy_a", int'(busy_a), 0);
        chk("midrst_busy_b", int'(busy_b), 0);
        reset  = 1'b0;
        last_a = 4'h0;
        last_b = 4'h0;
        step(1'b1, 1'b1, 1'b0);
        frame(4'b1100, 4'b0011, 1'b1, 1'b0);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
      end
      begin : monitor
        forever begin
          exp_t e;
          @(negedge clk);
          if (!reset) begin
            if (valid_a || ferr_a) begin
              if (qa.size() == 0) begin
                chk("unexpected_strobe_a", int'({valid_a, ferr_a}), 0);
              end else begin
                e = qa.pop_front();
                chk("kind_a", int'({valid_a, ferr_a}), e.err ? 1 : 2);
                chk("word_a", int'(par_a), int'(e.word));
              end
            end
            if (valid_b || ferr_b) begin
              if (qb.size() == 0) begin
                chk("unexpected_strobe_b", int'({valid_b, ferr_b}), 0);
              end else begin
                e = qb.pop_front();
                chk("kind_b", int'({valid_b, ferr_b}), e.err ? 1 : 2);
                chk("word_b", int'(par_b), int'(e.word));
              end
            end
          end
        end
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
